// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// Package rr_arb_defs: requester count, FSM encodings and the default
// hold limit. The default hold limit is also used by the encoder bench.
package rr_arb_defs;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned PTR_W = 2;

    // Hold limit applied when the build enables the timeout feature.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // True when v is zero or has exactly one bit set. These are the only
    // codes the downstream encoder is allowed to see.
    function automatic logic is_onehot0(input logic [N_REQ-1:0] v);
        return (v & (v - 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// rr_pick: combinational round-robin selector.
// The request vector is rotated so that the pointer position sits at bit 0.
// The lowest set bit is then chosen, and the chosen index is rotated back
// into absolute requester numbering.
module rr_pick
    import rr_arb_defs::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_onehot_o,
    output logic [PTR_W-1:0] pick_idx_o
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [PTR_W-1:0]   rel_idx;

    // Rotate, then scan downward so the lowest set bit wins, then rotate back.
    always_comb begin
        req_dbl = {req_i, req_i};
        req_rot = req_dbl[ptr_i +: N_REQ];
        rel_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rel_idx = PTR_W'(i);
            end
        end
        pick_idx_o    = rel_idx + ptr_i;
        pick_onehot_o = (|req_i) ? (N_REQ'(1) << pick_idx_o) : '0;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a registered
// one-hot grant that feeds a 4-to-2 one-hot encoder.
// Optional feature macro: RR_TIMEOUT_EN. When it is defined, a grant is
// force-released after TIMEOUT_CYCLES cycles and timeout_o pulses. When it
// is undefined, there is no hold counter and timeout_o is tied low.
//
// Handshake: a requester holds req_i[i] high for as long as it wants
// service. grant_o[i] is raised one cycle after the arbiter selects it.
// grant_o is held until release_i or a drop of req_i[i], and falls on the
// following edge. At least one all-zero grant cycle separates consecutive
// grants, so the encoder never sees two bits set.
module rr_arbiter_4
    import rr_arb_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    input  logic             release_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             grant_valid_o,
    output logic             timeout_o,
    output state_e           dbg_state_o,
    output logic [PTR_W-1:0] dbg_ptr_o
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0] pick_idx;
    logic             exit_normal;
    logic             exit_force;

    rr_pick u_pick (
        .req_i         (req_i),
        .ptr_i         (ptr_q),
        .pick_onehot_o (pick_onehot),
        .pick_idx_o    (pick_idx)
    );

    // A normal exit happens when the holder releases or stops requesting.
    assign exit_normal = (state_q == ST_GRANT) && (release_i || !req_i[idx_q]);

`ifdef RR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Hold counter: cleared while idle, so it starts at zero on each grant.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_GRANT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign exit_force = (state_q == ST_GRANT) && (cnt_q == CNT_LAST);
`else
    // Without the timeout feature the sizing parameters have no effect.
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
    assign exit_force = 1'b0;
`endif

    // State register: FSM state, priority pointer and index of the holder.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic. On an exit, the served requester drops to lowest priority.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_GRANT;
                    idx_d   = pick_idx;
                end
            end
            ST_GRANT: begin
                if (exit_normal || exit_force) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + PTR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered grant and timeout outputs.
    always_comb begin
        grant_d   = grant_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d = pick_onehot;
            end
            ST_GRANT: begin
                if (exit_normal || exit_force) begin
                    grant_d   = '0;
                    timeout_d = exit_force && !exit_normal;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
        grant_valid_d = |grant_d;
    end

    // Output registers. There is no combinational path from req_i to grant_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = grant_valid_q;
    assign timeout_o     = timeout_q;
    assign dbg_state_o   = state_q;
    assign dbg_ptr_o     = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4. It covers reset, round-robin order,
// pointer skip, request drop, asynchronous reset mid-grant, and the hold
// limit. When RR_TIMEOUT_EN is defined it checks the forced release;
// otherwise it checks that a grant can be held indefinitely.
module tb_rr_arbiter_4;
    import rr_arb_defs::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout;
    state_e     dbg_state;
    logic [1:0] dbg_ptr;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter_4 #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .release_i     (rel),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .timeout_o     (timeout),
        .dbg_state_o   (dbg_state),
        .dbg_ptr_o     (dbg_ptr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic t);
        chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
        chk({tag, ".gvalid"}, {31'd0, grant_valid}, {31'd0, (g != 4'd0)});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, t});
    endtask

    // Invariant checked every cycle: the grant is one-hot or zero, and
    // grant_valid agrees with it.
    always @(negedge clk) begin
        chk("inv.onehot0", {31'd0, ((grant & (grant - 4'd1)) == 4'd0)}, 32'd1);
        chk("inv.gvalid", {31'd0, grant_valid}, {31'd0, (grant != 4'd0)});
    end

    logic [3:0] rr_seq [9];

    initial begin
        rr_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};

        // Reset held for 3 cycles with every requester active
        rst_n = 1'b0;
        req   = 4'b1111;
        rel   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset", 4'b0000, 1'b0);
            chk("reset.state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
            chk("reset.ptr", {30'd0, dbg_ptr}, 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk_out("first_grant", 4'b0001, 1'b0);
        chk("first_grant.state", {31'd0, dbg_state}, {31'd0, ST_GRANT});

        // Round robin: release pulsed one cycle after each grant
        for (int i = 1; i < 9; i++) begin
            rel = (i % 2 == 1);
            step();
            chk_out($sformatf("rr%0d", i), rr_seq[i], 1'b0);
        end
        rel = 1'b0;

        // Pointer skip: holder is 0, so ptr becomes 1 after the release
        req = 4'b1001;
        rel = 1'b1;
        step();
        chk_out("skip.drop0", 4'b0000, 1'b0);
        chk("skip.ptr1", {30'd0, dbg_ptr}, 32'd1);
        rel = 1'b0;
        step();
        chk_out("skip.grant3", 4'b1000, 1'b0);
        rel = 1'b1;
        step();
        chk_out("skip.drop3", 4'b0000, 1'b0);
        chk("skip.ptr0", {30'd0, dbg_ptr}, 32'd0);
        rel = 1'b0;
        step();
        chk_out("skip.grant0", 4'b0001, 1'b0);
        rel = 1'b1;
        step();
        chk("skip.ptr1b", {30'd0, dbg_ptr}, 32'd1);
        rel = 1'b0;

        // Req drop: grant requester 2, toggle req[0], then drop req[2]
        req = 4'b0100;
        step();
        chk_out("drop.grant2", 4'b0100, 1'b0);
        req = 4'b0101;
        step();
        chk_out("drop.toggle_a", 4'b0100, 1'b0);
        req = 4'b0100;
        step();
        chk_out("drop.toggle_b", 4'b0100, 1'b0);
        req = 4'b0101;
        step();
        chk_out("drop.toggle_c", 4'b0100, 1'b0);
        req = 4'b0001;
        step();
        chk_out("drop.exit", 4'b0000, 1'b0);
        chk("drop.ptr3", {30'd0, dbg_ptr}, 32'd3);
        chk("drop.state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
        step();
        chk_out("drop.wrap0", 4'b0001, 1'b0);
        // Release while idle is ignored
        req = 4'b0000;
        step();
        chk_out("drop.idle", 4'b0000, 1'b0);
        rel = 1'b1;
        step();
        chk_out("rel_in_idle", 4'b0000, 1'b0);
        chk("rel_in_idle.ptr", {30'd0, dbg_ptr}, 32'd1);
        rel = 1'b0;

        // Asynchronous reset mid-grant
        req = 4'b0010;
        step();
        chk_out("areset.grant1", 4'b0010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("areset.cleared", 4'b0000, 1'b0);
        chk("areset.ptr", {30'd0, dbg_ptr}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk_out("areset.regrant", 4'b0010, 1'b0);
        chk("areset.ptr0", {30'd0, dbg_ptr}, 32'd0);
        rel = 1'b1;
        step();
        chk("areset.ptr2", {30'd0, dbg_ptr}, 32'd2);
        rel = 1'b0;

        // Hold limit with no release
        req = 4'b0011;
        step();
        chk_out("hold.c1", 4'b0001, 1'b0);
`ifdef RR_TIMEOUT_EN
        for (int i = 2; i <= 4; i++) begin
            step();
            chk_out($sformatf("hold.c%0d", i), 4'b0001, 1'b0);
        end
        step();
        chk_out("hold.timeout", 4'b0000, 1'b1);
        chk("hold.ptr1", {30'd0, dbg_ptr}, 32'd1);
        step();
        chk_out("hold.next", 4'b0010, 1'b0);
`else
        for (int i = 2; i <= 100; i++) begin
            step();
            chk_out($sformatf("hold.c%0d", i), 4'b0001, 1'b0);
        end
`endif
        req = 4'b0000;
        step();
        step();
        chk_out("end.idle", 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
